fp_mul_round_stage: RTL and testbench
=====================================

# fp_mul_round_stage

Post-multiply normalize/round/pack stage for the single-precision floating-point multiplier datapath. It consumes the raw 48-bit mantissa product, the unadjusted exponent sum, the sign and the special-operand flags from the combinational mantissa multiplier. It produces an IEEE-754 binary32 result with round-to-nearest-even, overflow, underflow and invalid detection. It is a 2-stage valid/ready pipeline with sticky exception flags.

## Interface
- XLEN, 32, result width; only 32 is supported.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream holds a product.
- in_ready  output  1  stage can accept this cycle.
- in_sign  input  1  A_sign ^ B_sign.
- in_exp  input  10  two's-complement EA+EB-127, range -127..+381.
- in_mant  input  48  {1,A[22:0]} * {1,B[22:0]}.
- in_nan  input  1  either operand is NaN.
- in_inf  input  1  either operand is infinity.
- in_zero  input  1  either operand is zero; subnormal inputs are treated as zero upstream.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts.
- out_result  output  XLEN  packed binary32.
- out_overflow, out_underflow, out_invalid  output  1 each  per-result flags, aligned with out_result.
- flag_clr  input  1  clears the sticky flags.
- flag_overflow, flag_underflow, flag_invalid  output  1 each  sticky flags.

## Operation
- Stage 1 (normalize), registered into s1:
  - If in_mant[47]=1: m = in_mant[46:24], g = in_mant[23], s = |in_mant[22:0], e = in_exp+1.
  - Otherwise: m = in_mant[45:23], g = in_mant[22], s = |in_mant[21:0], e = in_exp.
  - e is carried at 10 bits signed; the special flags and the sign pass through.
- Stage 2 (round/pack), registered into the output register:
  - round_up = g & (s | m[0]).
  - {c,mr} = {1'b0,m} + round_up.
  - If c=1: mr = 0 and e = e+1.
- Result priority:
  1. in_nan, or in_inf & in_zero: result 32'h7FC00000. invalid=1 only for inf*zero.
  2. in_inf: {sign,8'hFF,23'h0}, no flags.
  3. in_zero: {sign,31'h0}, no flags.
  4. e ≥ 255: {sign,8'hFF,23'h0}, overflow=1.
  5. e ≤ 0: flush to {sign,31'h0}, underflow=1. No subnormal output.
  6. Otherwise: {sign,e[7:0],mr}.
- Sticky flags:
  - A sticky flag is set on any output transfer (out_valid & out_ready) whose per-result flag is 1.
  - flag_clr clears the sticky flags. If clr and set happen in the same cycle, set wins.

## Timing
- Latency is 2 cycles from the in_valid & in_ready edge to out_valid. Throughput is 1 result per cycle.
- s2_adv = ~out_valid | out_ready.
- s1_adv = ~s1_valid | s2_adv.
- in_ready = s1_adv. This is combinational, with no combinational path from in_valid.
- While out_valid=1 and out_ready=0, out_result and the per-result flags hold stable. No bubbles are inserted and no data is lost under any out_ready pattern.
- An accept and an output transfer in the same cycle with both stages full keep the pipeline full.
- Reset, asynchronous and valid mid-operation:
  - s1_valid = 0, out_valid = 0, out_result = 0.
  - All per-result flags and sticky flags = 0.
  - In-flight data is discarded.
  - in_ready = 1 while reset is asserted and after release.

## Test plan
- in_exp=10'd128, in_mant=48'h600000000000 (1.5×2.0) -> out_result=32'h40400000 two cycles later, no flags.
- in_exp=10'd127, in_mant=48'h7FFFFFC00000 -> round carry -> out_result=32'h40000000.
- in_exp=10'd127, in_mant=48'h400000400000 (tie, even LSB) -> out_result=32'h3F800000, no round-up.
- in_exp=10'd254, in_mant=48'h800000000000 -> out_result=32'h7F800000, out_overflow=1, flag_overflow=1 until flag_clr. in_exp=10'd0, in_mant=48'h400000000000 -> 32'h00000000, underflow=1.
- in_inf=1, in_zero=1 -> 32'h7FC00000 with invalid=1. in_sign=1, in_inf=1 -> 32'hFF800000 with no flags.
- Stream 8 back-to-back products while out_ready toggles at random, with rst_n pulsed low once mid-stream:
  - Every accepted item emerges exactly once, in order, and stays stable while stalled.
  - After the reset pulse: out_valid=0, and flags=0.

Source files
------------

// File: rtl/fp_mul_round_stage.sv
// fp_mul_round_stage
// Post-multiply normalize / round / pack stage of the binary32 multiplier.
// Two registered stages joined by a valid/ready handshake:
//   s1  : normalized 23-bit mantissa, guard and sticky bits, biased exponent,
//         sign and the special-operand flags.
//   out : packed binary32 result plus its per-result exception flags.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid / in_ready          upstream handshake
//   in_sign, in_exp, in_mant     raw product fields (in_exp = EA+EB-127)
//   in_nan, in_inf, in_zero      special-operand flags from upstream
//   out_valid / out_ready        downstream handshake
//   out_result                   packed binary32, round-to-nearest-even
//   out_overflow/underflow/invalid  flags belonging to out_result
//   flag_clr                     clears the sticky flags
//   flag_overflow/underflow/invalid  sticky flags, set on flagged transfers
module fp_mul_round_stage #(
   parameter int XLEN = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_sign,
   input  logic signed [9:0]  in_exp,
   input  logic [47:0]        in_mant,
   input  logic               in_nan,
   input  logic               in_inf,
   input  logic               in_zero,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    out_result,
   output logic               out_overflow,
   output logic               out_underflow,
   output logic               out_invalid,
   input  logic               flag_clr,
   output logic               flag_overflow,
   output logic               flag_underflow,
   output logic               flag_invalid
);

   // Round-to-nearest-even followed by special-case / range packing.
   // Returns {overflow, underflow, invalid, result}.
   function automatic logic [XLEN+2:0] round_pack(
      input logic              sign,
      input logic signed [9:0] exp_in,
      input logic [22:0]       mant,
      input logic              guard,
      input logic              sticky,
      input logic              is_nan,
      input logic              is_inf,
      input logic              is_zero
   );
      logic              round_up;
      logic [23:0]       sum;
      logic [22:0]       mr;
      logic signed [9:0] e;
      round_up = guard & (sticky | mant[0]);
      sum      = {1'b0, mant} + {23'd0, round_up};
      mr       = sum[22:0];
      e        = exp_in;
      // Carry out of the mantissa: 1.111..1 rounded to 10.000..0
      if (sum[23]) begin
         mr = 23'd0;
         e  = exp_in + 10'sd1;
      end
      if (is_nan || (is_inf && is_zero))
         round_pack = {1'b0, 1'b0, is_inf & is_zero, 32'h7FC0_0000};
      else if (is_inf)
         round_pack = {3'b000, sign, 8'hFF, 23'd0};
      else if (is_zero)
         round_pack = {3'b000, sign, 31'd0};
      else if (e >= 10'sd255)
         round_pack = {3'b100, sign, 8'hFF, 23'd0};
      else if (e <= 10'sd0)
         round_pack = {3'b010, sign, 31'd0};
      else
         round_pack = {3'b000, sign, e[7:0], mr};
   endfunction

   logic              s1_valid_q, s1_valid_d;
   logic              s1_sign_q, s1_sign_d;
   logic signed [9:0] s1_exp_q, s1_exp_d;
   logic [22:0]       s1_mant_q, s1_mant_d;
   logic              s1_guard_q, s1_guard_d;
   logic              s1_sticky_q, s1_sticky_d;
   logic              s1_nan_q, s1_nan_d;
   logic              s1_inf_q, s1_inf_d;
   logic              s1_zero_q, s1_zero_d;

   logic              out_valid_q, out_valid_d;
   logic [XLEN-1:0]   out_result_q, out_result_d;
   logic              out_ovf_q, out_ovf_d;
   logic              out_unf_q, out_unf_d;
   logic              out_inv_q, out_inv_d;

   logic              flag_ovf_q, flag_ovf_d;
   logic              flag_unf_q, flag_unf_d;
   logic              flag_inv_q, flag_inv_d;

   logic              s1_adv, s2_adv, out_xfer;
   logic [XLEN+2:0]   pack_w;

   always_comb begin
      s2_adv   = ~out_valid_q | out_ready;
      s1_adv   = ~s1_valid_q | s2_adv;
      out_xfer = out_valid_q & out_ready;

      s1_valid_d  = s1_valid_q;
      s1_sign_d   = s1_sign_q;
      s1_exp_d    = s1_exp_q;
      s1_mant_d   = s1_mant_q;
      s1_guard_d  = s1_guard_q;
      s1_sticky_d = s1_sticky_q;
      s1_nan_d    = s1_nan_q;
      s1_inf_d    = s1_inf_q;
      s1_zero_d   = s1_zero_q;

      // ---- stage 1: normalize the 48-bit product into s1 ----
      if (s1_adv)
         s1_valid_d = in_valid;
      if (s1_adv && in_valid) begin
         s1_sign_d = in_sign;
         s1_nan_d  = in_nan;
         s1_inf_d  = in_inf;
         s1_zero_d = in_zero;
         // Product of two 1.x significands lies in [1,4): bit 47 selects a
         // one-position right shift with exponent increment.
         if (in_mant[47]) begin
            s1_mant_d   = in_mant[46:24];
            s1_guard_d  = in_mant[23];
            s1_sticky_d = |in_mant[22:0];
            s1_exp_d    = in_exp + 10'sd1;
         end else begin
            s1_mant_d   = in_mant[45:23];
            s1_guard_d  = in_mant[22];
            s1_sticky_d = |in_mant[21:0];
            s1_exp_d    = in_exp;
         end
      end

      // ---- stage 2: round and pack into the output register ----
      pack_w = round_pack(s1_sign_q, s1_exp_q, s1_mant_q, s1_guard_q,
                          s1_sticky_q, s1_nan_q, s1_inf_q, s1_zero_q);

      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      out_ovf_d    = out_ovf_q;
      out_unf_d    = out_unf_q;
      out_inv_d    = out_inv_q;
      if (s2_adv)
         out_valid_d = s1_valid_q;
      if (s2_adv && s1_valid_q) begin
         out_ovf_d    = pack_w[XLEN+2];
         out_unf_d    = pack_w[XLEN+1];
         out_inv_d    = pack_w[XLEN];
         out_result_d = pack_w[XLEN-1:0];
      end

      // Set has priority over clear so a flagged transfer is never lost.
      flag_ovf_d = (flag_ovf_q & ~flag_clr) | (out_xfer & out_ovf_q);
      flag_unf_d = (flag_unf_q & ~flag_clr) | (out_xfer & out_unf_q);
      flag_inv_d = (flag_inv_q & ~flag_clr) | (out_xfer & out_inv_q);
   end

   // Control, output register and sticky flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_ovf_q    <= 1'b0;
         out_unf_q    <= 1'b0;
         out_inv_q    <= 1'b0;
         flag_ovf_q   <= 1'b0;
         flag_unf_q   <= 1'b0;
         flag_inv_q   <= 1'b0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_ovf_q    <= out_ovf_d;
         out_unf_q    <= out_unf_d;
         out_inv_q    <= out_inv_d;
         flag_ovf_q   <= flag_ovf_d;
         flag_unf_q   <= flag_unf_d;
         flag_inv_q   <= flag_inv_d;
      end
   end

   // s1 payload is only meaningful under s1_valid_q, so it carries no reset.
   always_ff @(posedge clk) begin
      s1_sign_q   <= s1_sign_d;
      s1_exp_q    <= s1_exp_d;
      s1_mant_q   <= s1_mant_d;
      s1_guard_q  <= s1_guard_d;
      s1_sticky_q <= s1_sticky_d;
      s1_nan_q    <= s1_nan_d;
      s1_inf_q    <= s1_inf_d;
      s1_zero_q   <= s1_zero_d;
   end

   assign in_ready       = s1_adv;
   assign out_valid      = out_valid_q;
   assign out_result     = out_result_q;
   assign out_overflow   = out_ovf_q;
   assign out_underflow  = out_unf_q;
   assign out_invalid    = out_inv_q;
   assign flag_overflow  = flag_ovf_q;
   assign flag_underflow = flag_unf_q;
   assign flag_invalid   = flag_inv_q;

endmodule

// File: tb/tb_fp_mul_round_stage.sv
// Testbench for fp_mul_round_stage: directed vectors, sticky-flag behaviour,
// back-to-back streaming and a randomly stalled stream with a reset pulse,
// all checked against a value-level reference model.
module tb_fp_mul_round_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [9:0]  in_exp;
   logic [47:0] in_mant;
   logic        in_nan, in_inf, in_zero;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_overflow, out_underflow, out_invalid;
   logic        flag_clr;
   logic        flag_overflow, flag_underflow, flag_invalid;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fp_mul_round_stage #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
      .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result),
      .out_overflow(out_overflow), .out_underflow(out_underflow),
      .out_invalid(out_invalid),
      .flag_clr(flag_clr),
      .flag_overflow(flag_overflow), .flag_underflow(flag_underflow),
      .flag_invalid(flag_invalid)
   );

   // Reference: treat the product as an integer significand, round it to
   // 24 significant bits by remainder comparison, then apply the range rules.
   // Returns {overflow, underflow, invalid, result}.
   function automatic logic [34:0] model(input logic sg, input logic [9:0] ex,
                                         input logic [47:0] mn, input logic na,
                                         input logic fi, input logic fz);
      int e;
      int sh;
      longint unsigned q, rem, half;
      if (na || (fi && fz)) return {1'b0, 1'b0, fi && fz, 32'h7FC00000};
      if (fi) return {3'b000, sg, 8'hFF, 23'h0};
      if (fz) return {3'b000, sg, 31'h0};
      e  = $signed(ex);
      sh = mn[47] ? 24 : 23;
      if (mn[47]) e = e + 1;
      q    = 64'(mn) >> sh;
      rem  = 64'(mn) & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q == (64'd1 << 24)) begin
         q = 64'd1 << 23;
         e = e + 1;
      end
      if (e >= 255) return {3'b100, sg, 8'hFF, 23'h0};
      if (e <= 0) return {3'b010, sg, 31'h0};
      return {3'b000, sg, e[7:0], q[22:0]};
   endfunction

   // Presents one item on an empty pipeline and returns the observed output
   // and the number of falling edges until out_valid appeared.
   task automatic run_one(input logic sg, input logic [9:0] ex, input logic [47:0] mn,
                          input logic na, input logic fi, input logic fz,
                          output logic [34:0] obs, output int lat);
      @(negedge clk);
      in_valid = 1'b1; in_sign = sg; in_exp = ex; in_mant = mn;
      in_nan = na; in_inf = fi; in_zero = fz; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      #1;
      while (!out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
         #1;
      end
      obs = {out_overflow, out_underflow, out_invalid, out_result};
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
      in_sign = 1'b0; in_exp = '0; in_mant = '0;
      in_nan = 1'b0; in_inf = 1'b0; in_zero = 1'b0;
      #3;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      n_cmp++;
      if (out_result !== 32'h0) begin
         n_fail++; $display("FAIL reset_out_result: got %h want 00000000", out_result);
      end
      n_cmp++;
      if ({out_overflow, out_underflow, out_invalid, flag_overflow, flag_underflow, flag_invalid} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b%b%b %b%b%b want all 0", out_overflow, out_underflow,
                  out_invalid, flag_overflow, flag_underflow, flag_invalid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready);
      end
   endtask

   typedef struct packed {
      logic        sg;
      logic [9:0]  ex;
      logic [47:0] mn;
      logic        na, fi, fz;
      logic [34:0] want;
   } vec_t;

   task automatic test_directed;
      vec_t        tbl[12];
      logic [34:0] obs;
      int          lat;
      tbl[0]  = '{1'b0, 10'd128, 48'h600000000000, 1'b0, 1'b0, 1'b0, {3'b000, 32'h40400000}};
      tbl[1]  = '{1'b0, 10'd127, 48'h7FFFFFC00000, 1'b0, 1'b0, 1'b0, {3'b000, 32'h40000000}};
      tbl[2]  = '{1'b0, 10'd127, 48'h400000400000, 1'b0, 1'b0, 1'b0, {3'b000, 32'h3F800000}};
      tbl[3]  = '{1'b1, 10'd127, 48'h400000C00000, 1'b0, 1'b0, 1'b0, {3'b000, 32'hBF800002}};
      tbl[4]  = '{1'b0, 10'd254, 48'h800000000000, 1'b0, 1'b0, 1'b0, {3'b100, 32'h7F800000}};
      tbl[5]  = '{1'b0, 10'd253, 48'h7FFFFFC00000, 1'b0, 1'b0, 1'b0, {3'b000, 32'h7F000000}};
      tbl[6]  = '{1'b0, 10'd0,   48'h400000000000, 1'b0, 1'b0, 1'b0, {3'b010, 32'h00000000}};
      tbl[7]  = '{1'b0, 10'd1,   48'h400000000000, 1'b0, 1'b0, 1'b0, {3'b000, 32'h00800000}};
      tbl[8]  = '{1'b1, 10'h381, 48'h400000000000, 1'b0, 1'b0, 1'b0, {3'b010, 32'h80000000}};
      tbl[9]  = '{1'b0, 10'd0,   48'h0,            1'b0, 1'b1, 1'b1, {3'b001, 32'h7FC00000}};
      tbl[10] = '{1'b1, 10'd0,   48'h0,            1'b0, 1'b1, 1'b0, {3'b000, 32'hFF800000}};
      tbl[11] = '{1'b1, 10'd200, 48'hC00000000000, 1'b0, 1'b0, 1'b1, {3'b000, 32'h80000000}};
      for (int i = 0; i < 12; i++) begin
         run_one(tbl[i].sg, tbl[i].ex, tbl[i].mn, tbl[i].na, tbl[i].fi, tbl[i].fz, obs, lat);
         n_cmp++;
         if (lat !== 2) begin
            n_fail++; $display("FAIL directed_latency[%0d]: got %0d want 2", i, lat);
         end
         n_cmp++;
         if (obs !== tbl[i].want) begin
            n_fail++;
            $display("FAIL directed_result[%0d]: got flags=%b res=%h want flags=%b res=%h",
                     i, obs[34:32], obs[31:0], tbl[i].want[34:32], tbl[i].want[31:0]);
         end
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if ({flag_overflow, flag_underflow, flag_invalid} !== 3'b111) begin
         n_fail++;
         $display("FAIL directed_sticky: got %b%b%b want 111", flag_overflow, flag_underflow, flag_invalid);
      end
   endtask

   task automatic test_sticky;
      logic [34:0] obs;
      int          lat;
      logic [31:0] held;
      @(negedge clk); flag_clr = 1'b1;
      @(negedge clk); flag_clr = 1'b0;
      #1;
      n_cmp++;
      if ({flag_overflow, flag_underflow, flag_invalid} !== 3'b000) begin
         n_fail++;
         $display("FAIL sticky_clear_all: got %b%b%b want 000", flag_overflow, flag_underflow, flag_invalid);
      end
      run_one(1'b0, 10'd254, 48'h800000000000, 1'b0, 1'b0, 1'b0, obs, lat);
      @(negedge clk); #1;
      n_cmp++;
      if ({flag_overflow, flag_underflow} !== 2'b10) begin
         n_fail++; $display("FAIL sticky_set: got ovf=%b unf=%b want 1 0", flag_overflow, flag_underflow);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (flag_overflow !== 1'b1) begin
         n_fail++; $display("FAIL sticky_hold: got %b want 1", flag_overflow);
      end
      @(negedge clk); flag_clr = 1'b1;
      @(negedge clk); flag_clr = 1'b0;
      #1;
      n_cmp++;
      if (flag_overflow !== 1'b0) begin
         n_fail++; $display("FAIL sticky_clr: got %b want 0", flag_overflow);
      end
      // Stalled overflow result, then transfer coinciding with a clear.
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_sign = 1'b1; in_exp = 10'd254;
      in_mant = 48'h800000000000; in_nan = 1'b0; in_inf = 1'b0; in_zero = 1'b0;
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1) begin
         n_fail++; $display("FAIL stall_valid: got %b want 1", out_valid);
      end
      held = out_result;
      @(negedge clk); #1;
      n_cmp++;
      if ({out_valid, out_overflow, out_result} !== {2'b11, 32'hFF800000} || out_result !== held) begin
         n_fail++;
         $display("FAIL stall_hold: got v=%b ovf=%b res=%h want v=1 ovf=1 res=ff800000",
                  out_valid, out_overflow, out_result);
      end
      out_ready = 1'b1; flag_clr = 1'b1;
      @(negedge clk);
      out_ready = 1'b0; flag_clr = 1'b0;
      #1;
      n_cmp++;
      if ({flag_overflow, out_valid} !== 2'b10) begin
         n_fail++; $display("FAIL sticky_set_wins: got flag=%b v=%b want 1 0", flag_overflow, out_valid);
      end
      @(negedge clk); flag_clr = 1'b1;
      @(negedge clk); flag_clr = 1'b0;
   endtask

   // Streams n_items; rand_mode randomizes in_valid/out_ready, otherwise both
   // stay high. reset_after >= 0 pulses rst_n once that many items are in.
   task automatic test_stream(input int n_items, input bit rand_mode, input int reset_after);
      logic [34:0] exp_q[$];
      logic [34:0] want, held, obs;
      int          sent = 0;
      int          cyc = 0;
      bit          did_rst = 1'b0;
      bit          stalled = 1'b0;
      int          r;
      held = '0;
      while (cyc < 500) begin
         @(negedge clk);
         cyc++;
         if (sent >= n_items && exp_q.size() == 0 && !out_valid) break;
         if (!did_rst && reset_after >= 0 && sent == reset_after) begin
            in_valid = 1'b0; out_ready = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            n_cmp++;
            if ({out_valid, in_ready, out_result} !== {2'b01, 32'h0}) begin
               n_fail++;
               $display("FAIL stream_reset_state: got v=%b rdy=%b res=%h want v=0 rdy=1 res=0",
                        out_valid, in_ready, out_result);
            end
            n_cmp++;
            if ({out_overflow, out_underflow, out_invalid, flag_overflow, flag_underflow, flag_invalid} !== 6'b0) begin
               n_fail++;
               $display("FAIL stream_reset_flags: got %b%b%b %b%b%b want all 0", out_overflow,
                        out_underflow, out_invalid, flag_overflow, flag_underflow, flag_invalid);
            end
            #1 rst_n = 1'b1;
            exp_q.delete();
            stalled = 1'b0;
            did_rst = 1'b1;
            continue;
         end
         in_valid = (sent < n_items) && (rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
         in_sign  = 1'($urandom);
         r        = $urandom_range(0, 508);
         in_exp   = 10'(r - 127);
         in_mant  = 48'({1'b1, 23'($urandom)}) * 48'({1'b1, 23'($urandom)});
         in_nan   = ($urandom_range(0, 15) == 0);
         in_inf   = ($urandom_range(0, 11) == 0);
         in_zero  = ($urandom_range(0, 11) == 0);
         out_ready = rand_mode ? 1'($urandom) : 1'b1;
         #1;
         obs = {out_overflow, out_underflow, out_invalid, out_result};
         if (stalled) begin
            n_cmp++;
            if (out_valid !== 1'b1 || obs !== held) begin
               n_fail++;
               $display("FAIL stream_stall_stable: got v=%b out=%h want v=1 out=%h", out_valid, obs, held);
            end
         end
         if (!rand_mode && sent < n_items) begin
            n_cmp++;
            if (in_ready !== 1'b1) begin
               n_fail++; $display("FAIL b2b_in_ready: got %b want 1", in_ready);
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(in_sign, in_exp, in_mant, in_nan, in_inf, in_zero));
            sent++;
         end
         if (out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL stream_extra_output: got %h want none", obs);
            end else begin
               want = exp_q.pop_front();
               if (obs !== want) begin
                  n_fail++;
                  $display("FAIL stream_result: got flags=%b res=%h want flags=%b res=%h",
                           obs[34:32], obs[31:0], want[34:32], want[31:0]);
               end
            end
         end
         stalled = out_valid && !out_ready;
         held    = obs;
      end
      n_cmp++;
      if (cyc >= 500 || exp_q.size() != 0 || sent != n_items) begin
         n_fail++;
         $display("FAIL stream_drain: got sent=%0d pending=%0d cycles=%0d want sent=%0d pending=0",
                  sent, exp_q.size(), cyc, n_items);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_sticky();
      test_stream(8, 1'b0, -1);
      test_stream(8, 1'b1, 4);
      test_stream(40, 1'b1, -1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
